// File: rtl/swbut_in.sv
// Switch/button front end: synchronizes and debounces raw pins into the `in` word,
// emits one-cycle press pulses and offers a button-0 snapshot on a valid/ready handshake.
module swbut_in #(
    parameter int N_SW     = 15,
    parameter int N_BUT    = 1,
    parameter int DEBOUNCE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SW-1:0]       sw_raw,
    input  logic [N_BUT-1:0]      but_raw,
    output logic [N_SW+N_BUT-1:0] in,
    output logic [N_BUT-1:0]      but_press,
    output logic [N_SW+N_BUT-1:0] snap,
    output logic                  snap_valid,
    input  logic                  snap_ready,
    output logic                  overflow
);

    localparam int W  = N_SW + N_BUT;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [W-1:0]     s1_q, s2_q;
    logic [W-1:0]     stable_q, stable_d;
    logic [CW-1:0]    cnt_q [W];
    logic [CW-1:0]    cnt_d [W];
    logic [N_BUT-1:0] press_q, press_d;
    logic [W-1:0]     snap_q, snap_d;
    logic             snap_valid_q, snap_valid_d;
    logic             overflow_q, overflow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {but_raw, sw_raw};
            s2_q <= s1_q;
        end
    end

    // Each bit only adopts the synchronized level after it has disagreed for DEBOUNCE edges.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Pulse is registered with the stable bit so it coincides with the first cycle `in` shows 1.
    assign press_d = stable_d[W-1:N_SW] & ~stable_q[W-1:N_SW];

    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        overflow_d   = overflow_q;
        if (!snap_valid_q) begin
            if (press_q[0]) begin
                snap_d       = stable_q;
                snap_valid_d = 1'b1;
            end
        end else if (snap_ready) begin
            if (press_q[0]) begin
                snap_d = stable_q;
            end else begin
                snap_valid_d = 1'b0;
            end
        end else if (press_q[0]) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= '0;
            press_q      <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q     <= stable_d;
            press_q      <= press_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in         = stable_q;
    assign but_press  = press_q;
    assign snap       = snap_q;
    assign snap_valid = snap_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_swbut_in.sv
// Directed bench for swbut_in with DEBOUNCE=4; snapshot transfers are checked by a
// queue-based scoreboard on the valid/ready handshake, levels and flags checked inline.
module tb_swbut_in;

    logic        clk;
    logic        rst_n;
    logic [14:0] sw_raw;
    logic [0:0]  but_raw;
    logic [15:0] in;
    logic [0:0]  but_press;
    logic [15:0] snap;
    logic        snap_valid;
    logic        snap_ready;
    logic        overflow;

    int nChecks = 0;
    int nFails  = 0;
    logic [15:0] expQ[$];

    swbut_in #(.N_SW(15), .N_BUT(1), .DEBOUNCE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .but_raw    (but_raw),
        .in         (in),
        .but_press  (but_press),
        .snap       (snap),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] sw, input logic but, input logic rdy);
        sw_raw     = sw;
        but_raw[0] = but;
        snap_ready = rdy;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press button 0 from a released state; returns right after the edge that shows the pulse.
    task automatic pressButton(input logic [14:0] sw, input logic [15:0] expWord);
        applyStimulus(sw, 1'b1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checkOutput($sformatf("press_in_e%0d", e), in, (e == 6) ? expWord : {1'b0, sw});
        end
        checkOutput("press_pulse", {15'd0, but_press}, 16'h0001);
    endtask

    // Scoreboard monitor: every accepted transfer must match the oldest expected capture.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && snap_valid && snap_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_xfer", snap, 16'hxxxx);
                end else begin
                    checkOutput("sb_xfer", snap, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(15'h0000, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst_in", in, 16'h0000);
        checkOutput("rst_snap", snap, 16'h0000);
        checkOutput("rst_flags", {13'd0, but_press, snap_valid, overflow}, 16'h0000);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] scenario 1: switch debounce latency");
        applyStimulus(15'h0001, 1'b0, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checkOutput($sformatf("s1_in_e%0d", e), in, (e == 6) ? 16'h0001 : 16'h0000);
            checkOutput($sformatf("s1_flags_e%0d", e), {13'd0, but_press, snap_valid, overflow}, 16'h0000);
        end

        $display("[TB] scenario 2: glitch rejection");
        applyStimulus(15'h0009, 1'b0, 1'b0);
        tick(3);
        applyStimulus(15'h0001, 1'b0, 1'b0);
        for (int e = 4; e <= 12; e++) begin
            tick(1);
            checkOutput($sformatf("s2_short_e%0d", e), in, 16'h0001);
        end
        applyStimulus(15'h0009, 1'b0, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            if (e == 4) applyStimulus(15'h0001, 1'b0, 1'b0);
            checkOutput($sformatf("s2_long_e%0d", e), in, (e == 6) ? 16'h0009 : 16'h0001);
        end
        tick(10);
        checkOutput("s2_settle", in, 16'h0001);

        $display("[TB] scenario 3: first capture");
        pressButton(15'h0001, 16'h8001);
        expQ.push_back(16'h8001);
        tick(1);
        checkOutput("s3_pulse_gone", {15'd0, but_press}, 16'h0000);
        checkOutput("s3_snap", snap, 16'h8001);
        for (int e = 0; e < 5; e++) begin
            tick(1);
            checkOutput($sformatf("s3_hold_%0d", e), {15'd0, snap_valid}, 16'h0001);
        end

        $display("[TB] scenario 4: dropped press sets overflow");
        applyStimulus(15'h0001, 1'b0, 1'b0);
        tick(8);
        checkOutput("s4_release_in", in, 16'h0001);
        checkOutput("s4_ovf_before", {15'd0, overflow}, 16'h0000);
        pressButton(15'h0001, 16'h8001);
        tick(1);
        checkOutput("s4_ovf", {15'd0, overflow}, 16'h0001);
        checkOutput("s4_snap_kept", snap, 16'h8001);
        checkOutput("s4_valid_kept", {15'd0, snap_valid}, 16'h0001);
        applyStimulus(15'h0001, 1'b1, 1'b1);
        tick(1);
        applyStimulus(15'h0001, 1'b1, 1'b0);
        checkOutput("s4_consumed", {15'd0, snap_valid}, 16'h0000);

        $display("[TB] scenario 6: async reset mid-debounce with capture pending");
        applyStimulus(15'h0001, 1'b0, 1'b0);
        tick(8);
        pressButton(15'h0001, 16'h8001);
        expQ.push_back(16'h8001);
        tick(1);
        checkOutput("s6_pending", {15'd0, snap_valid}, 16'h0001);
        applyStimulus(15'h0003, 1'b1, 1'b0);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_rst_in", in, 16'h0000);
        checkOutput("s6_rst_snap", snap, 16'h0000);
        checkOutput("s6_rst_flags", {13'd0, but_press, snap_valid, overflow}, 16'h0000);
        expQ.delete();
        applyStimulus(15'h0001, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(8);
        checkOutput("s6_resettle_in", in, 16'h0001);
        checkOutput("s6_resettle_valid", {15'd0, snap_valid}, 16'h0000);
        pressButton(15'h0001, 16'h8001);
        expQ.push_back(16'h8001);
        tick(2);
        checkOutput("s6_fresh_snap", snap, 16'h8001);
        checkOutput("s6_fresh_flags", {14'd0, snap_valid, overflow}, 16'h0002);

        $display("[TB] scenario 5: back-to-back transfer");
        applyStimulus(15'h0002, 1'b0, 1'b0);
        tick(8);
        checkOutput("s5_in", in, 16'h0002);
        checkOutput("s5_still_valid", {15'd0, snap_valid}, 16'h0001);
        pressButton(15'h0002, 16'h8002);
        expQ.push_back(16'h8002);
        applyStimulus(15'h0002, 1'b1, 1'b1);
        tick(1);
        applyStimulus(15'h0002, 1'b1, 1'b0);
        checkOutput("s5_snap", snap, 16'h8002);
        checkOutput("s5_flags", {14'd0, snap_valid, overflow}, 16'h0002);
        tick(2);
        applyStimulus(15'h0002, 1'b1, 1'b1);
        tick(1);
        applyStimulus(15'h0002, 1'b1, 1'b0);
        checkOutput("s5_drained", {15'd0, snap_valid}, 16'h0000);
        tick(2);
        checkOutput("sb_queue_empty", 16'(expQ.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/swbut_in.md
Name: swbut_in

Overview:
- Board-side front end for the switch/button interface consumed by `top` through its 16-bit `in` bus. It is the producer end of the `in` interface.
- Raw switch and button pins are synchronized and debounced, then packed into the `in` word: buttons in the high bits, switches in the low bits.
- Also generates one-cycle press pulses.
- On a press of button 0, captures a snapshot of the word and offers it on a valid/ready handshake for sequencing logic, for example a start/load command to the collatz core.

Parameters:
- N_SW, 15, number of switch inputs; occupies `in[N_SW-1:0]`.
- N_BUT, 1, number of button inputs; occupies `in[N_SW+N_BUT-1:N_SW]`.
- DEBOUNCE, 16, consecutive cycles a synchronized level must differ from the stable level before the stable level changes; minimum 1.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_raw  input  N_SW  raw, asynchronous switch pins.
- but_raw  input  N_BUT  raw, asynchronous button pins; 1 = pressed.
- in  output  N_SW+N_BUT  debounced level word `{but_stable, sw_stable}`; drives `top.in`.
- but_press  output  N_BUT  one-cycle pulse per button on a stable 0->1 transition.
- snap  output  N_SW+N_BUT  word captured on a button-0 press.
- snap_valid  output  1  `snap` holds an unconsumed capture.
- snap_ready  input  1  consumer accepts `snap` when `snap_valid && snap_ready` at a rising edge.
- overflow  output  1  sticky flag: a button-0 press was dropped because a capture was still pending.

Behaviour:
- Reset (async assert, sync-to-clk release handled externally):
  - All synchronizer flops, stable bits, counters, `in`, `but_press`, `snap`, `snap_valid` and `overflow` = 0.
  - Reset mid-debounce or with a capture pending discards all state immediately.
- Synchronizer: two flops per bit, with no logic between them. `s2` is the second-stage output.
- Debounce, independent per bit:
  - Counter width is clog2(DEBOUNCE+1).
  - Edge where `s2 == stable`: counter cleared to 0.
  - Edge where `s2 != stable` and counter == DEBOUNCE-1: `stable` <= `s2`, counter <= 0.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE cycles never reaches `stable`.
  - Latency from a clean raw transition to `in` changing = 2 + DEBOUNCE rising edges.
- `but_press[i]` is asserted for exactly the one cycle in which `in[N_SW+i]` first reads 1, i.e. it is registered alongside the stable bit. Release produces no pulse.
- Snapshot, evaluated each edge with `press0 = but_press[0]`:
  - `snap_valid=0`, `press0=1`: `snap` <= `in`, `snap_valid` <= 1.
  - `snap_valid=1`, `snap_ready=1`, `press0=0`: `snap_valid` <= 0; `snap` holds its value.
  - `snap_valid=1`, `snap_ready=1`, `press0=1`: `snap` <= `in`, `snap_valid` stays 1. This is a back-to-back transfer and is not an overflow.
  - `snap_valid=1`, `snap_ready=0`, `press0=1`: `snap` unchanged, `overflow` <= 1.
  - `overflow` clears only on reset.
- The capture uses the `in` value present in the press cycle, which includes button 0 = 1.
- `snap` and `snap_valid` must not change while `snap_valid=1 && snap_ready=0`, apart from the overflow flag.
- `snap_ready` while `snap_valid=0` is ignored.
- `but_press` bits other than bit 0 never affect `snap`.

Test Plan:
All scenarios use DEBOUNCE=4, N_SW=15, N_BUT=1.
1. Reset, then drive `sw_raw=15'h0001`, `but_raw=0` steady -> `in` = 16'h0000 through edge 5; `in`=16'h0001 at edge 6. `but_press`, `snap_valid` and `overflow` stay 0.
2. A 3-cycle pulse on `sw_raw[3]`, then back to 0 -> `in[3]` never rises. A 4-cycle pulse -> `in[3]` rises 6 edges after the pulse starts.
3. `sw_raw=15'h0001` settled, `but_raw` 0->1 held, `snap_ready=0` -> `in`=16'h8001. `but_press` high for exactly one cycle. Next edge: `snap`=16'h8001, `snap_valid`=1 and held indefinitely.
4. Continuing 3: release and re-press the button while `snap_ready=0` -> `overflow`=1 and `snap` is still 16'h8001. Raise `snap_ready` for one cycle -> `snap_valid`=0.
5. Pending capture with `snap_ready=1` in the exact cycle `but_press` pulses, switches now 15'h0002 -> `snap`=16'h8002, `snap_valid` remains 1, `overflow` unchanged.
6. Deassert `rst_n` asynchronously mid-debounce with `snap_valid=1` -> every output is 0 before the next clock edge. After release, an 8-edge clean press produces a fresh capture.
